vector_sequencer: RTL and testbench
===================================

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 The block SHALL be parameterised by SETTLE_CYCLES, default 8, meaning the number of clk cycles the driven vector is held before y_i is sampled; 8 covers the 7 ns worst-case path of the downstream 3-input gate network at a 1 ns clk.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to run one full 8-vector sweep.
REQ-005 The block SHALL have port abc_o, output, 3 bits: vector driven to the gate network, bit 2 = a, bit 1 = b, bit 0 = c.
REQ-006 The block SHALL have port y_i, input, 1 bit: the gate network's y response.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep completion.
REQ-009 The block SHALL have port err_count, output, 4 bits: mismatches in the last sweep, 0..8.
REQ-010 The block SHALL have port pass, output, 1 bit: high after a sweep with err_count == 0, held until the next sweep starts.

Function
REQ-011 The block SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-012 In IDLE with start == 1, on the next edge the block SHALL set idx = 0, abc_o = 3'b000, load the settle counter with SETTLE_CYCLES-1, clear err_count and pass, assert busy, and enter SETTLE.
REQ-013 In SETTLE the block SHALL decrement the counter each cycle and enter SAMPLE on the cycle the counter equals 0.
REQ-014 In SAMPLE the block SHALL compare y_i with GOLDEN[idx] and increment err_count on mismatch; err_count SHALL saturate at 8.
REQ-015 In SAMPLE with idx < 7, the block SHALL set idx = idx+1 and abc_o = idx+1, reload the counter, and re-enter SETTLE.
REQ-016 In SAMPLE with idx == 7, the block SHALL enter DONE.
REQ-017 In DONE the block SHALL assert done for exactly one cycle, set pass = (final err_count == 0), deassert busy, and return to IDLE.
REQ-018 Latency SHALL be exactly SETTLE_CYCLES+1 cycles per vector; done SHALL assert 8*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge.
REQ-019 abc_o SHALL change only on vector advance and SHALL be stable throughout SETTLE and SAMPLE.
REQ-020 start SHALL be ignored whenever the state is not IDLE, including in the DONE cycle.
REQ-021 An SETTLE_CYCLES value of 0 SHALL be treated as 1.
REQ-022 err_count and pass SHALL retain their last-sweep values in IDLE until the next start is accepted.

Reset
REQ-023 On reset the block SHALL enter IDLE with abc_o = 0, busy = 0, done = 0, err_count = 0 and pass = 0.
REQ-024 Reset SHALL take priority over start and over every state, including mid-sweep; an aborted sweep SHALL NOT produce done.

Configuration
REQ-025 With VECSEQ_MISMATCH_LOG_EN defined, the block SHALL add output mismatch_mask, 8 bits, where bit idx is set when vector idx mismatched; the mask SHALL clear on start-accept and reset.
REQ-026 Without VECSEQ_MISMATCH_LOG_EN defined, the mismatch_mask port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 The package vecseq_pkg SHALL hold the FSM state enum and the localparam GOLDEN = 8'b0011_0001 (bit i = expected y for abc == i, i.e. y = ~b & (~c | a)).
REQ-028 The settle counter SHALL be a sub-module settle_timer (load, tick, zero flag) with width $clog2(SETTLE_CYCLES+1).

Verification
REQ-029 With a correct gate model (7 ns delay) and SETTLE_CYCLES = 8, start pulsed once -> done after 73 cycles, err_count = 0, pass = 1, abc_o sequence 0..7.
REQ-030 With y_i forced to 0 -> err_count = 3, pass = 0, mismatch_mask = 8'b0011_0001 when VECSEQ_MISMATCH_LOG_EN is defined.
REQ-031 With SETTLE_CYCLES = 2 against the 7 ns model -> at least one mismatch is sampled, and done asserts at cycle 25.
REQ-032 With reset asserted at cycle 30 mid-sweep -> the next cycle shows IDLE outputs all zero and no done pulse; a new start then completes normally.
REQ-033 With start held high continuously -> only one sweep runs per IDLE entry, busy stays low during the DONE cycle, and the next sweep begins the cycle after DONE.

Source files
------------

// File: rtl/vecseq_pkg.sv
// Shared types and constants for the vector sequencer: FSM state encoding and
// the expected gate response table (y = ~b & (~c | a), bit i = abc value i).
package vecseq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] GOLDEN  = 8'b0011_0001;
  localparam logic [3:0] ERR_MAX = 4'd8;

endpackage

// File: rtl/settle_timer.sv
// Down-counter holding a vector for a fixed number of cycles; load wins over
// tick, and the count parks at zero instead of wrapping.
module settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vector_sequencer.sv
// Sweeps abc_o through 0..7, waits SETTLE_CYCLES per vector, checks y_i against GOLDEN.
// Optional feature: define VECSEQ_MISMATCH_LOG_EN to add the per-vector mismatch_mask output.
module vector_sequencer
  import vecseq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] abc_o,
  input  logic       y_i,
  output logic       busy,
  output logic       done,
  output logic [3:0] err_count,
  output logic       pass
`ifdef VECSEQ_MISMATCH_LOG_EN
  ,
  output logic [7:0] mismatch_mask
`endif
);

  // A zero settle time still needs one cycle in SETTLE to keep the per-vector cadence.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CW = $clog2(SETTLE_EFF + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_EFF - 1);

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic       accept, advance, sample, finish, tick, zero, miss;

  settle_timer #(
    .WIDTH(CW)
  ) u_settle_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (accept | advance),
    .load_value(RELOAD),
    .tick      (tick),
    .zero      (zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    sample    = 1'b0;
    finish    = 1'b0;
    tick      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        tick = 1'b1;
        if (zero) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        sample = 1'b1;
        if (idx == 3'd7) begin
          state_nxt = DONE;
        end else begin
          advance   = 1'b1;
          state_nxt = SETTLE;
        end
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign miss  = sample && (y_i != GOLDEN[idx]);
  assign abc_o = idx;

  // busy drops on entry to DONE; done and pass land together on the way back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= 4'd0;
      pass      <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        idx       <= 3'd0;
        busy      <= 1'b1;
        err_count <= 4'd0;
        pass      <= 1'b0;
      end
      if (miss && err_count != ERR_MAX) err_count <= err_count + 4'd1;
      if (advance) idx <= idx + 3'd1;
      if (sample && idx == 3'd7) busy <= 1'b0;
      if (finish) pass <= (err_count == 4'd0);
    end
  end

`ifdef VECSEQ_MISMATCH_LOG_EN
  always_ff @(posedge clk) begin
    if (reset || accept) mismatch_mask <= 8'd0;
    else if (miss)       mismatch_mask[idx] <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench: two sequencers (settle 8 and 2) each drive a gate model with a
// 7-clock transport delay; one clock period stands for 1 ns.
module tb_vector_sequencer;

  localparam int GATE_DELAY = 14;  // 7 clock periods of 2 time units

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, start2 = 1'b0;
  logic       force0 = 1'b0;
  logic [2:0] abc, abc2;
  logic       busy, done, pass, busy2, done2, pass2;
  logic [3:0] err, err2;
  logic       y_gate = 1'b1, y_gate2 = 1'b1;
  logic       y_in;
`ifdef VECSEQ_MISMATCH_LOG_EN
  logic [7:0] mask, mask2;
`endif

  int vec = 0, miss = 0;
  int lat;
  logic [2:0] seq [$];
  logic pass_at_accept;

  always #1 clk = ~clk;

  function automatic logic gate_fn(input logic [2:0] v);
    return ~v[1] & (~v[0] | v[2]);
  endfunction

  always @(abc)  y_gate  <= #GATE_DELAY gate_fn(abc);
  always @(abc2) y_gate2 <= #GATE_DELAY gate_fn(abc2);
  assign y_in = force0 ? 1'b0 : y_gate;

  vector_sequencer #(.SETTLE_CYCLES(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abc_o(abc), .y_i(y_in),
    .busy(busy), .done(done), .err_count(err), .pass(pass)
`ifdef VECSEQ_MISMATCH_LOG_EN
    , .mismatch_mask(mask)
`endif
  );

  vector_sequencer #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .reset(reset), .start(start2), .abc_o(abc2), .y_i(y_gate2),
    .busy(busy2), .done(done2), .err_count(err2), .pass(pass2)
`ifdef VECSEQ_MISMATCH_LOG_EN
    , .mismatch_mask(mask2)
`endif
  );

  // Stimulus only: pulse start, then count cycles after the accept edge until done.
  task automatic run_sweep(input bit use_s2);
    int c;
    logic [2:0] last, cur;
    seq.delete();
    if (use_s2) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
    pass_at_accept = use_s2 ? pass2 : pass;
    c = 0;
    last = use_s2 ? abc2 : abc;
    seq.push_back(last);
    while (!(use_s2 ? done2 : done) && c < 400) begin
      @(negedge clk);
      c++;
      cur = use_s2 ? abc2 : abc;
      if (cur !== last) begin
        seq.push_back(cur);
        last = cur;
      end
    end
    lat = c;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (30) @(negedge clk);
    vec++; if (abc !== 3'd0) begin miss++; $display("FAIL reset_abc: got %0d expected 0", abc); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vec++; if (done !== 1'b0) begin miss++; $display("FAIL reset_done: got %0b expected 0", done); end
    vec++; if (err !== 4'd0) begin miss++; $display("FAIL reset_err: got %0d expected 0", err); end
    vec++; if (pass !== 1'b0) begin miss++; $display("FAIL reset_pass: got %0b expected 0", pass); end
`ifdef VECSEQ_MISMATCH_LOG_EN
    vec++; if (mask !== 8'd0) begin miss++; $display("FAIL reset_mask: got %h expected 00", mask); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_golden_sweep;
    run_sweep(1'b0);
    vec++; if (lat !== 73) begin miss++; $display("FAIL golden_latency: got %0d expected 73", lat); end
    vec++; if (err !== 4'd0) begin miss++; $display("FAIL golden_err: got %0d expected 0", err); end
    vec++; if (pass !== 1'b1) begin miss++; $display("FAIL golden_pass: got %0b expected 1", pass); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL golden_busy_at_done: got %0b expected 0", busy); end
    vec++; if (seq.size() !== 8) begin miss++; $display("FAIL golden_seq_len: got %0d expected 8", seq.size()); end
    for (int i = 0; i < 8 && i < seq.size(); i++) begin
      vec++;
      if (seq[i] !== 3'(i)) begin miss++; $display("FAIL golden_seq[%0d]: got %0d expected %0d", i, seq[i], i); end
    end
    @(negedge clk);
    vec++; if (done !== 1'b0) begin miss++; $display("FAIL golden_done_width: got %0b expected 0", done); end
    repeat (5) @(negedge clk);
    vec++; if (pass !== 1'b1) begin miss++; $display("FAIL idle_pass_hold: got %0b expected 1", pass); end
    vec++; if (err !== 4'd0) begin miss++; $display("FAIL idle_err_hold: got %0d expected 0", err); end
  endtask

  task automatic test_y_zero;
    force0 = 1'b1;
    run_sweep(1'b0);
    vec++; if (pass_at_accept !== 1'b0) begin miss++; $display("FAIL yzero_pass_clear: got %0b expected 0", pass_at_accept); end
    vec++; if (lat !== 73) begin miss++; $display("FAIL yzero_latency: got %0d expected 73", lat); end
    vec++; if (err !== 4'd3) begin miss++; $display("FAIL yzero_err: got %0d expected 3", err); end
    vec++; if (pass !== 1'b0) begin miss++; $display("FAIL yzero_pass: got %0b expected 0", pass); end
`ifdef VECSEQ_MISMATCH_LOG_EN
    vec++; if (mask !== 8'b0011_0001) begin miss++; $display("FAIL yzero_mask: got %h expected 31", mask); end
`endif
    repeat (3) @(negedge clk);
    vec++; if (err !== 4'd3) begin miss++; $display("FAIL yzero_err_hold: got %0d expected 3", err); end
    force0 = 1'b0;
  endtask

  task automatic test_reset_mid;
    int dones;
    force0 = 1'b1;  // vector 0 mismatches early, so the abort has a nonzero err_count to clear
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    vec++; if (err !== 4'd1) begin miss++; $display("FAIL midsweep_err_before: got %0d expected 1", err); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    force0 = 1'b0;
    vec++; if (abc !== 3'd0) begin miss++; $display("FAIL abort_abc: got %0d expected 0", abc); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    vec++; if (err !== 4'd0) begin miss++; $display("FAIL abort_err: got %0d expected 0", err); end
    vec++; if (pass !== 1'b0) begin miss++; $display("FAIL abort_pass: got %0b expected 0", pass); end
`ifdef VECSEQ_MISMATCH_LOG_EN
    vec++; if (mask !== 8'd0) begin miss++; $display("FAIL abort_mask: got %h expected 00", mask); end
`endif
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    vec++; if (dones !== 0) begin miss++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
    run_sweep(1'b0);
    vec++; if (lat !== 73) begin miss++; $display("FAIL restart_latency: got %0d expected 73", lat); end
    vec++; if (err !== 4'd0 || pass !== 1'b1) begin
      miss++; $display("FAIL restart_result: got err=%0d pass=%0b expected err=0 pass=1", err, pass);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_short_settle;
    run_sweep(1'b1);
    vec++; if (lat !== 25) begin miss++; $display("FAIL s2_latency: got %0d expected 25", lat); end
    vec++; if (!(err2 >= 4'd1 && err2 <= 4'd8)) begin miss++; $display("FAIL s2_err: got %0d expected 1..8", err2); end
    vec++; if (pass2 !== 1'b0) begin miss++; $display("FAIL s2_pass: got %0b expected 0", pass2); end
    vec++; if (seq.size() !== 8) begin miss++; $display("FAIL s2_seq_len: got %0d expected 8", seq.size()); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int c;
    logic prev_busy;
    start = 1'b1;
    c = 0;
    prev_busy = busy;
    while (done !== 1'b1 && c < 400) begin
      prev_busy = busy;
      @(negedge clk);
      c++;
    end
    vec++; if (done !== 1'b1) begin miss++; $display("FAIL b2b_first_done: timed out after %0d cycles", c); end
    vec++; if (busy !== 1'b0 || prev_busy !== 1'b0) begin
      miss++; $display("FAIL b2b_busy_low: got done-cycle busy=%0b prior busy=%0b expected 0 0", busy, prev_busy);
    end
    @(negedge clk);
    vec++; if (busy !== 1'b1 || done !== 1'b0) begin
      miss++; $display("FAIL b2b_restart: got busy=%0b done=%0b expected 1 0", busy, done);
    end
    c = 1;
    while (done !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    vec++; if (c !== 74) begin miss++; $display("FAIL b2b_period: got %0d expected 74", c); end
    start = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL b2b_stop: got busy=%0b expected 0", busy); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_golden_sweep();
    test_y_zero();
    test_reset_mid();
    test_short_settle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
